dma_channel_arbiter: RTL and testbench
======================================

# dma_channel_arbiter

Merges the NoC per-channel TileLink-UL master ports of the multi-channel DMA controller into one shared TileLink-UL master port toward the system interconnect. Round-robin schedules A-channel beats between channels, tags each request with its channel index in the source field, and routes D-channel responses back by source. Each channel may have one outstanding transaction; different channels may overlap.

## Interface
Parameters:
- NoC, 1, number of DMA channels arbitrated.
- TL_RS, 4, source width; must be ≥ CW, where CW = max(1, clog2(NoC)).

Ports:
- arb_clock_i  in  1  clock; all logic on rising edge.
- arb_resetn_i  in  1  synchronous, active-low reset.
- ca_opcode/ca_param  in  3*NoC each  channel A opcode/param, channel i at [3i+2:3i].
- ca_size  in  4*NoC  channel A size.
- ca_address/ca_data  in  32*NoC each  channel A address/data.
- ca_mask  in  4*NoC  channel A byte mask.
- ca_corrupt/ca_valid  in  NoC each  channel A corrupt/valid.
- ca_ready  out  NoC  channel A ready.
- cd_opcode  out  3*NoC; cd_param  out  2*NoC; cd_size  out  4*NoC; cd_denied/cd_corrupt/cd_valid  out  NoC each; cd_data  out  32*NoC  per-channel D outputs.
- cd_ready  in  NoC  per-channel D ready.
- m_a_opcode 3, m_a_param 3, m_a_size 4, m_a_source TL_RS, m_a_address 32, m_a_mask 4, m_a_data 32, m_a_corrupt 1, m_a_valid 1  out  shared A.
- m_a_ready  in  1.
- m_d_opcode 3, m_d_param 2, m_d_size 4, m_d_source TL_RS, m_d_denied 1, m_d_data 32, m_d_corrupt 1, m_d_valid 1  in  shared D.
- m_d_ready  out  1.
- pending_o  out  NoC  per-channel outstanding flag.
- stray_err_o  out  1  sticky: D response with no matching pending channel.

## Operation
- State: pending[NoC], rr_ptr[CW] (highest-priority channel), output A register (m_a_* incl. m_a_valid), stray_err.
- eligible[i] = ca_valid[i] & ~pending[i].
- Winner = first eligible channel scanning rr_ptr, rr_ptr+1, … modulo NoC (wrap at NoC, not 2^CW).
- Load enable: ld = any eligible & (~m_a_valid | m_a_ready).
- ca_ready[i] = ld & (winner == i); all other ca_ready low; pending channels never see ca_ready.
- On ld: output register ← winner's A fields; m_a_source ← zero-extended winner index; m_a_valid ← 1; pending[winner] ← 1; rr_ptr ← winner+1 mod NoC.
- If m_a_valid & m_a_ready & ~ld: m_a_valid ← 0. Register holds stable while m_a_valid & ~m_a_ready.
- D routing (combinational): idx = m_d_source[CW-1:0]; hit = m_d_valid & (m_d_source < NoC) & pending[idx].
- cd_valid[i] = hit & (idx == i); cd_* data fields broadcast from m_d_* to all channels.
- m_d_ready = hit ? cd_ready[idx] : 1 (non-hit responses drained).
- On m_d_valid & m_d_ready & hit: pending[idx] ← 0.
- On m_d_valid & ~hit: stray_err ← 1, response discarded; only cleared by reset.
- Same channel cannot both set and clear pending in one cycle (set requires ~pending, clear requires pending); different channels set/clear independently.
- NoC = 1: winner always 0, rr_ptr constant 0.

## Timing
- Reset (arb_resetn_i low at edge): m_a_valid 0, pending 0, rr_ptr 0, stray_err_o 0; other m_a_* regs 0. ca_ready, cd_valid, m_d_ready are combinational from reset state (ca_ready follows ld; m_d_ready 1 when m_d_valid low).
- Reset mid-operation: outstanding transactions forgotten; later responses count as stray.
- A latency: channel beat accepted in cycle N appears on m_a_* in N+1. Full throughput: one beat per cycle when m_a_ready held high.
- D latency: zero cycles, combinational pass-through; no D buffering.
- Channel may reissue in the cycle after its D handshake completes.
- m_a_* never change while m_a_valid & ~m_a_ready (TileLink stability).

## Test plan
- NoC=1: ca_valid with write 0x1000/0xDEADBEEF -> m_a_valid next cycle, source 0, address 0x1000; ca_ready low until AccessAck source 0 handshakes; pending_o 1 → 0.
- NoC=4, all channels valid same cycle, m_a_ready=1, responses immediate -> grant order 0,1,2,3, then 0 again; m_a_source matches.
- m_a_ready low 5 cycles with beat from ch2 -> m_a_* stable, all ca_ready low, beat issued on cycle m_a_ready rises; next winner loaded same cycle.
- Out-of-order D: ch1 and ch3 outstanding, respond source 3 then 1 -> cd_valid[3] then cd_valid[1]; cd_ready[3]=0 for 2 cycles holds m_d_ready low.
- Stray: D with source 2 while pending_o=0, or source 5 with NoC=4 -> m_d_ready 1, no cd_valid, stray_err_o 1 persists.
- Reset asserted with 2 outstanding -> pending_o 0, m_a_valid 0, rr_ptr 0 next cycle; first grant after reset goes to lowest valid channel.

Source files
------------

// File: rtl/dma_channel_arbiter_if.sv
// Port bundle for dma_channel_arbiter: per-channel TileLink-UL A/D ports and the shared master port.
// The master modport is the arbiter's view; the slave modport is the DMA channels plus interconnect.
interface dma_channel_arbiter_if #(
  parameter int NoC   = 1,
  parameter int TL_RS = 4
);
  logic [3*NoC-1:0]  ca_opcode;
  logic [3*NoC-1:0]  ca_param;
  logic [4*NoC-1:0]  ca_size;
  logic [32*NoC-1:0] ca_address;
  logic [32*NoC-1:0] ca_data;
  logic [4*NoC-1:0]  ca_mask;
  logic [NoC-1:0]    ca_corrupt;
  logic [NoC-1:0]    ca_valid;
  logic [NoC-1:0]    ca_ready;

  logic [3*NoC-1:0]  cd_opcode;
  logic [2*NoC-1:0]  cd_param;
  logic [4*NoC-1:0]  cd_size;
  logic [NoC-1:0]    cd_denied;
  logic [NoC-1:0]    cd_corrupt;
  logic [NoC-1:0]    cd_valid;
  logic [32*NoC-1:0] cd_data;
  logic [NoC-1:0]    cd_ready;

  logic [2:0]        m_a_opcode;
  logic [2:0]        m_a_param;
  logic [3:0]        m_a_size;
  logic [TL_RS-1:0]  m_a_source;
  logic [31:0]       m_a_address;
  logic [3:0]        m_a_mask;
  logic [31:0]       m_a_data;
  logic              m_a_corrupt;
  logic              m_a_valid;
  logic              m_a_ready;

  logic [2:0]        m_d_opcode;
  logic [1:0]        m_d_param;
  logic [3:0]        m_d_size;
  logic [TL_RS-1:0]  m_d_source;
  logic              m_d_denied;
  logic [31:0]       m_d_data;
  logic              m_d_corrupt;
  logic              m_d_valid;
  logic              m_d_ready;

  modport master (
    input  ca_opcode, ca_param, ca_size, ca_address, ca_data, ca_mask, ca_corrupt, ca_valid,
    output ca_ready,
    output cd_opcode, cd_param, cd_size, cd_denied, cd_corrupt, cd_valid, cd_data,
    input  cd_ready,
    output m_a_opcode, m_a_param, m_a_size, m_a_source, m_a_address, m_a_mask, m_a_data,
    output m_a_corrupt, m_a_valid,
    input  m_a_ready,
    input  m_d_opcode, m_d_param, m_d_size, m_d_source, m_d_denied, m_d_data, m_d_corrupt,
    input  m_d_valid,
    output m_d_ready
  );

  modport slave (
    output ca_opcode, ca_param, ca_size, ca_address, ca_data, ca_mask, ca_corrupt, ca_valid,
    input  ca_ready,
    input  cd_opcode, cd_param, cd_size, cd_denied, cd_corrupt, cd_valid, cd_data,
    output cd_ready,
    input  m_a_opcode, m_a_param, m_a_size, m_a_source, m_a_address, m_a_mask, m_a_data,
    input  m_a_corrupt, m_a_valid,
    output m_a_ready,
    output m_d_opcode, m_d_param, m_d_size, m_d_source, m_d_denied, m_d_data, m_d_corrupt,
    output m_d_valid,
    input  m_d_ready
  );
endinterface

// File: rtl/dma_channel_arbiter.sv
// Round-robin merge of NoC DMA TileLink-UL master ports onto one shared port; the channel index
// travels in the source field and D responses are steered back by it. One outstanding per channel.
module dma_channel_arbiter #(
  parameter int NoC   = 1,
  parameter int TL_RS = 4
) (
  input  logic                 arb_clock_i,
  input  logic                 arb_resetn_i,
  dma_channel_arbiter_if.master bus,
  output logic [NoC-1:0]       pending_o,
  output logic                 stray_err_o
);
  localparam int CW = (NoC > 1) ? $clog2(NoC) : 1;
  typedef logic [CW-1:0] chan_t;

  // (base + k) mod NoC; both operands are below NoC so one subtraction suffices.
  function automatic chan_t wrap_add(chan_t base, int k);
    logic [CW:0] sum;
    sum = {1'b0, base} + (CW+1)'(k);
    if (sum >= (CW+1)'(NoC)) begin
      sum = sum - (CW+1)'(NoC);
    end
    return chan_t'(sum);
  endfunction

  logic [NoC-1:0]   pending_reg, pending_next;
  chan_t            rr_ptr_reg, rr_ptr_next;
  logic             stray_reg, stray_next;

  logic             a_valid_reg;
  logic [2:0]       a_opcode_reg;
  logic [2:0]       a_param_reg;
  logic [3:0]       a_size_reg;
  logic [TL_RS-1:0] a_source_reg;
  logic [31:0]      a_address_reg;
  logic [3:0]       a_mask_reg;
  logic [31:0]      a_data_reg;
  logic             a_corrupt_reg;

  logic [NoC-1:0]   eligible;
  logic [NoC-1:0]   grant_vec;
  logic [NoC-1:0]   hit_vec;
  chan_t            winner;
  logic             any_eligible;
  logic             ld;
  chan_t            d_idx;
  logic             src_in_range;
  logic             hit;
  logic             d_ready;

  logic [2:0]       sel_opcode;
  logic [2:0]       sel_param;
  logic [3:0]       sel_size;
  logic [31:0]      sel_address;
  logic [3:0]       sel_mask;
  logic [31:0]      sel_data;
  logic             sel_corrupt;

  assign d_idx        = bus.m_d_source[CW-1:0];
  assign src_in_range = 32'(bus.m_d_source) < 32'(NoC);

  for (genvar gi = 0; gi < NoC; gi++) begin : g_chan
    assign eligible[gi]  = bus.ca_valid[gi] & ~pending_reg[gi];
    assign grant_vec[gi] = ld & (winner == chan_t'(gi));
    assign hit_vec[gi]   = bus.m_d_valid & src_in_range & (d_idx == chan_t'(gi)) & pending_reg[gi];
  end

  // Scan from the highest k down so the channel closest to rr_ptr wins.
  always_comb begin
    winner       = '0;
    any_eligible = 1'b0;
    for (int k = NoC - 1; k >= 0; k--) begin
      if (|(eligible & (NoC'(1) << wrap_add(rr_ptr_reg, k)))) begin
        winner       = wrap_add(rr_ptr_reg, k);
        any_eligible = 1'b1;
      end
    end
  end

  assign ld = any_eligible & (~a_valid_reg | bus.m_a_ready);

  always_comb begin
    sel_opcode  = '0;
    sel_param   = '0;
    sel_size    = '0;
    sel_address = '0;
    sel_mask    = '0;
    sel_data    = '0;
    sel_corrupt = 1'b0;
    for (int i = 0; i < NoC; i++) begin
      if (winner == chan_t'(i)) begin
        sel_opcode  = bus.ca_opcode[3*i +: 3];
        sel_param   = bus.ca_param[3*i +: 3];
        sel_size    = bus.ca_size[4*i +: 4];
        sel_address = bus.ca_address[32*i +: 32];
        sel_mask    = bus.ca_mask[4*i +: 4];
        sel_data    = bus.ca_data[32*i +: 32];
        sel_corrupt = bus.ca_corrupt[i];
      end
    end
  end

  // Responses that match no pending channel are drained rather than stalling the interconnect.
  assign hit     = |hit_vec;
  assign d_ready = ~hit | (|(hit_vec & bus.cd_ready));

  always_comb begin
    pending_next = pending_reg;
    rr_ptr_next  = rr_ptr_reg;
    stray_next   = stray_reg | (bus.m_d_valid & ~hit);
    if (ld) begin
      pending_next = pending_next | grant_vec;
      rr_ptr_next  = wrap_add(winner, 1);
    end
    if (d_ready) begin
      pending_next = pending_next & ~hit_vec;
    end
  end

  always_ff @(posedge arb_clock_i) begin
    if (!arb_resetn_i) begin
      pending_reg   <= '0;
      rr_ptr_reg    <= '0;
      stray_reg     <= 1'b0;
      a_valid_reg   <= 1'b0;
      a_opcode_reg  <= '0;
      a_param_reg   <= '0;
      a_size_reg    <= '0;
      a_source_reg  <= '0;
      a_address_reg <= '0;
      a_mask_reg    <= '0;
      a_data_reg    <= '0;
      a_corrupt_reg <= 1'b0;
    end else begin
      pending_reg <= pending_next;
      rr_ptr_reg  <= rr_ptr_next;
      stray_reg   <= stray_next;
      if (ld) begin
        a_valid_reg   <= 1'b1;
        a_opcode_reg  <= sel_opcode;
        a_param_reg   <= sel_param;
        a_size_reg    <= sel_size;
        a_source_reg  <= TL_RS'(winner);
        a_address_reg <= sel_address;
        a_mask_reg    <= sel_mask;
        a_data_reg    <= sel_data;
        a_corrupt_reg <= sel_corrupt;
      end else if (a_valid_reg & bus.m_a_ready) begin
        a_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.ca_ready    = grant_vec;
  assign bus.cd_valid    = hit_vec;
  assign bus.cd_opcode   = {NoC{bus.m_d_opcode}};
  assign bus.cd_param    = {NoC{bus.m_d_param}};
  assign bus.cd_size     = {NoC{bus.m_d_size}};
  assign bus.cd_denied   = {NoC{bus.m_d_denied}};
  assign bus.cd_corrupt  = {NoC{bus.m_d_corrupt}};
  assign bus.cd_data     = {NoC{bus.m_d_data}};
  assign bus.m_d_ready   = d_ready;

  assign bus.m_a_valid   = a_valid_reg;
  assign bus.m_a_opcode  = a_opcode_reg;
  assign bus.m_a_param   = a_param_reg;
  assign bus.m_a_size    = a_size_reg;
  assign bus.m_a_source  = a_source_reg;
  assign bus.m_a_address = a_address_reg;
  assign bus.m_a_mask    = a_mask_reg;
  assign bus.m_a_data    = a_data_reg;
  assign bus.m_a_corrupt = a_corrupt_reg;

  assign pending_o   = pending_reg;
  assign stray_err_o = stray_reg;
endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Directed bench: a per-cycle vector table drives a 4-channel arbiter, plus hand sequences for the
// single-channel build and for reset with transactions outstanding.
module tb_dma_channel_arbiter;
  logic clk = 1'b0;
  logic rstn1, rstn4;
  logic [0:0] pend1;
  logic [3:0] pend4;
  logic stray1, stray4;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dma_channel_arbiter_if #(.NoC(1), .TL_RS(4)) bus1();
  dma_channel_arbiter_if #(.NoC(4), .TL_RS(4)) bus4();

  dma_channel_arbiter #(.NoC(1), .TL_RS(4)) u1 (
    .arb_clock_i(clk), .arb_resetn_i(rstn1), .bus(bus1), .pending_o(pend1), .stray_err_o(stray1)
  );
  dma_channel_arbiter #(.NoC(4), .TL_RS(4)) u4 (
    .arb_clock_i(clk), .arb_resetn_i(rstn4), .bus(bus4), .pending_o(pend4), .stray_err_o(stray4)
  );

  typedef struct {
    logic [3:0]  ca_valid;
    logic        a_ready;
    logic        d_valid;
    logic [3:0]  d_src;
    logic [3:0]  cd_ready;
    logic [3:0]  exp_ca_ready;
    logic        exp_d_ready;
    logic [3:0]  exp_cd_valid;
    logic        exp_a_valid;
    logic [3:0]  exp_a_src;
    logic [31:0] exp_addr;
    logic [3:0]  exp_pend;
    logic        exp_stray;
  } vec_t;

  vec_t vecs[26];

  function automatic vec_t mk(logic [3:0] cv, logic ar, logic dv, logic [3:0] ds, logic [3:0] cdr,
                              logic [3:0] ecr, logic edr, logic [3:0] ecdv, logic eav,
                              logic [3:0] esrc, logic [31:0] eaddr, logic [3:0] epend, logic es);
    vec_t v;
    v.ca_valid = cv; v.a_ready = ar; v.d_valid = dv; v.d_src = ds; v.cd_ready = cdr;
    v.exp_ca_ready = ecr; v.exp_d_ready = edr; v.exp_cd_valid = ecdv; v.exp_a_valid = eav;
    v.exp_a_src = esrc; v.exp_addr = eaddr; v.exp_pend = epend; v.exp_stray = es;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    // Row columns: ca_valid, m_a_ready, m_d_valid, m_d_source, cd_ready |
    //   ca_ready, m_d_ready, cd_valid, m_a_valid, m_a_source, m_a_address, pending, stray
    vecs[0]  = mk(4'b1111, 1'b1, 1'b0, 4'd0, 4'b1111, 4'b0001, 1'b1, 4'b0000, 1'b0, 4'd0, 32'h0000, 4'b0000, 1'b0);
    vecs[1]  = mk(4'b1111, 1'b1, 1'b1, 4'd0, 4'b1111, 4'b0010, 1'b1, 4'b0001, 1'b1, 4'd0, 32'h1000, 4'b0001, 1'b0);
    vecs[2]  = mk(4'b1111, 1'b1, 1'b1, 4'd1, 4'b1111, 4'b0100, 1'b1, 4'b0010, 1'b1, 4'd1, 32'h2000, 4'b0010, 1'b0);
    vecs[3]  = mk(4'b1111, 1'b1, 1'b1, 4'd2, 4'b1111, 4'b1000, 1'b1, 4'b0100, 1'b1, 4'd2, 32'h3000, 4'b0100, 1'b0);
    vecs[4]  = mk(4'b1111, 1'b1, 1'b1, 4'd3, 4'b1111, 4'b0001, 1'b1, 4'b1000, 1'b1, 4'd3, 32'h4000, 4'b1000, 1'b0);
    vecs[5]  = mk(4'b0000, 1'b1, 1'b1, 4'd0, 4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, 4'd0, 32'h1000, 4'b0001, 1'b0);
    vecs[6]  = mk(4'b0000, 1'b1, 1'b0, 4'd0, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'd0, 32'h1000, 4'b0000, 1'b0);
    vecs[7]  = mk(4'b0100, 1'b0, 1'b0, 4'd0, 4'b1111, 4'b0100, 1'b1, 4'b0000, 1'b0, 4'd0, 32'h1000, 4'b0000, 1'b0);
    for (int r = 8; r <= 12; r++)
      vecs[r] = mk(4'b0011, 1'b0, 1'b0, 4'd0, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 4'd2, 32'h3000, 4'b0100, 1'b0);
    vecs[13] = mk(4'b0011, 1'b1, 1'b0, 4'd0, 4'b1111, 4'b0001, 1'b1, 4'b0000, 1'b1, 4'd2, 32'h3000, 4'b0100, 1'b0);
    vecs[14] = mk(4'b0010, 1'b0, 1'b0, 4'd0, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 4'd0, 32'h1000, 4'b0101, 1'b0);
    vecs[15] = mk(4'b0010, 1'b1, 1'b0, 4'd0, 4'b1111, 4'b0010, 1'b1, 4'b0000, 1'b1, 4'd0, 32'h1000, 4'b0101, 1'b0);
    vecs[16] = mk(4'b0000, 1'b1, 1'b1, 4'd2, 4'b1111, 4'b0000, 1'b1, 4'b0100, 1'b1, 4'd1, 32'h2000, 4'b0111, 1'b0);
    vecs[17] = mk(4'b0000, 1'b1, 1'b1, 4'd0, 4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b0, 4'd1, 32'h2000, 4'b0011, 1'b0);
    vecs[18] = mk(4'b1000, 1'b1, 1'b0, 4'd0, 4'b1111, 4'b1000, 1'b1, 4'b0000, 1'b0, 4'd1, 32'h2000, 4'b0010, 1'b0);
    vecs[19] = mk(4'b0000, 1'b1, 1'b1, 4'd3, 4'b0111, 4'b0000, 1'b0, 4'b1000, 1'b1, 4'd3, 32'h4000, 4'b1010, 1'b0);
    vecs[20] = mk(4'b0000, 1'b1, 1'b1, 4'd3, 4'b0111, 4'b0000, 1'b0, 4'b1000, 1'b0, 4'd3, 32'h4000, 4'b1010, 1'b0);
    vecs[21] = mk(4'b0000, 1'b1, 1'b1, 4'd3, 4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b0, 4'd3, 32'h4000, 4'b1010, 1'b0);
    vecs[22] = mk(4'b0000, 1'b1, 1'b1, 4'd1, 4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b0, 4'd3, 32'h4000, 4'b0010, 1'b0);
    vecs[23] = mk(4'b0000, 1'b1, 1'b1, 4'd2, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'd3, 32'h4000, 4'b0000, 1'b0);
    vecs[24] = mk(4'b0000, 1'b1, 1'b1, 4'd5, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'd3, 32'h4000, 4'b0000, 1'b1);
    vecs[25] = mk(4'b0000, 1'b1, 1'b0, 4'd0, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'd3, 32'h4000, 4'b0000, 1'b1);

    bus1.ca_opcode = '0; bus1.ca_param = '0; bus1.ca_size = '0; bus1.ca_address = '0;
    bus1.ca_data = '0; bus1.ca_mask = '0; bus1.ca_corrupt = '0; bus1.ca_valid = '0;
    bus1.cd_ready = '0; bus1.m_a_ready = 1'b0; bus1.m_d_opcode = '0; bus1.m_d_param = '0;
    bus1.m_d_size = '0; bus1.m_d_source = '0; bus1.m_d_denied = 1'b0; bus1.m_d_data = '0;
    bus1.m_d_corrupt = 1'b0; bus1.m_d_valid = 1'b0;
    bus4.ca_opcode = {4{3'd4}}; bus4.ca_param = '0; bus4.ca_size = {4{4'd2}};
    bus4.ca_mask = {4{4'hF}}; bus4.ca_corrupt = '0; bus4.ca_valid = '0;
    for (int i = 0; i < 4; i++) begin
      bus4.ca_address[32*i +: 32] = 32'h1000 * (i + 1);
      bus4.ca_data[32*i +: 32]    = 32'hA000_0000 + i;
    end
    bus4.cd_ready = '0; bus4.m_a_ready = 1'b0; bus4.m_d_opcode = '0; bus4.m_d_param = '0;
    bus4.m_d_size = '0; bus4.m_d_source = '0; bus4.m_d_denied = 1'b0; bus4.m_d_data = '0;
    bus4.m_d_corrupt = 1'b0; bus4.m_d_valid = 1'b0;

    rstn1 = 1'b0; rstn4 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn1 = 1'b1; rstn4 = 1'b1;
    #1;
    check("reset m_a_valid", 32'(bus4.m_a_valid), 32'd0);
    check("reset pending", 32'(pend4), 32'd0);
    check("reset stray", 32'(stray4), 32'd0);
    check("reset m_d_ready", 32'(bus4.m_d_ready), 32'd1);
    check("reset ca_ready", 32'(bus4.ca_ready), 32'd0);
    check("reset m_a_address", bus4.m_a_address, 32'd0);

    for (int r = 0; r < 26; r++) begin
      @(negedge clk);
      bus4.ca_valid   = vecs[r].ca_valid;
      bus4.m_a_ready  = vecs[r].a_ready;
      bus4.m_d_valid  = vecs[r].d_valid;
      bus4.m_d_source = vecs[r].d_src;
      bus4.cd_ready   = vecs[r].cd_ready;
      #1;
      check($sformatf("row%0d ca_ready", r), 32'(bus4.ca_ready), 32'(vecs[r].exp_ca_ready));
      check($sformatf("row%0d m_d_ready", r), 32'(bus4.m_d_ready), 32'(vecs[r].exp_d_ready));
      check($sformatf("row%0d cd_valid", r), 32'(bus4.cd_valid), 32'(vecs[r].exp_cd_valid));
      check($sformatf("row%0d m_a_valid", r), 32'(bus4.m_a_valid), 32'(vecs[r].exp_a_valid));
      check($sformatf("row%0d m_a_source", r), 32'(bus4.m_a_source), 32'(vecs[r].exp_a_src));
      check($sformatf("row%0d m_a_address", r), bus4.m_a_address, vecs[r].exp_addr);
      check($sformatf("row%0d pending", r), 32'(pend4), 32'(vecs[r].exp_pend));
      check($sformatf("row%0d stray", r), 32'(stray4), 32'(vecs[r].exp_stray));
    end

    // Single-channel build: PutFullData, stall, AccessAck, reissue.
    @(negedge clk);
    bus1.ca_valid = 1'b1; bus1.ca_opcode = 3'd0; bus1.ca_address = 32'h1000;
    bus1.ca_data = 32'hDEADBEEF; bus1.ca_mask = 4'hF; bus1.ca_size = 4'd2; bus1.m_a_ready = 1'b0;
    #1;
    check("n1 ca_ready first", 32'(bus1.ca_ready), 32'd1);
    check("n1 pending before", 32'(pend1), 32'd0);
    @(negedge clk); #1;
    check("n1 m_a_valid", 32'(bus1.m_a_valid), 32'd1);
    check("n1 m_a_source", 32'(bus1.m_a_source), 32'd0);
    check("n1 m_a_address", bus1.m_a_address, 32'h1000);
    check("n1 m_a_data", bus1.m_a_data, 32'hDEADBEEF);
    check("n1 ca_ready pending", 32'(bus1.ca_ready), 32'd0);
    check("n1 pending set", 32'(pend1), 32'd1);
    bus1.m_a_ready = 1'b1;
    @(negedge clk); #1;
    check("n1 m_a_valid drop", 32'(bus1.m_a_valid), 32'd0);
    check("n1 ca_ready still low", 32'(bus1.ca_ready), 32'd0);
    bus1.m_d_valid = 1'b1; bus1.m_d_opcode = 3'd0; bus1.m_d_source = 4'd0;
    bus1.m_d_data = 32'h1234_5678; bus1.cd_ready = 1'b1;
    #1;
    check("n1 cd_valid", 32'(bus1.cd_valid), 32'd1);
    check("n1 m_d_ready", 32'(bus1.m_d_ready), 32'd1);
    check("n1 cd_data", bus1.cd_data, 32'h1234_5678);
    @(negedge clk);
    bus1.m_d_valid = 1'b0;
    #1;
    check("n1 pending clear", 32'(pend1), 32'd0);
    check("n1 reissue ca_ready", 32'(bus1.ca_ready), 32'd1);
    check("n1 stray", 32'(stray1), 32'd0);
    bus1.ca_valid = 1'b0;

    // Reset with two channels outstanding; rr_ptr would otherwise favour channel 3.
    @(negedge clk);
    bus4.ca_valid = 4'b0110; bus4.m_a_ready = 1'b1; bus4.m_d_valid = 1'b0; bus4.cd_ready = 4'b1111;
    #1;
    check("rst grant ch1", 32'(bus4.ca_ready), 32'b0010);
    @(negedge clk); #1;
    check("rst grant ch2", 32'(bus4.ca_ready), 32'b0100);
    check("rst pending one", 32'(pend4), 32'b0010);
    @(negedge clk);
    bus4.ca_valid = 4'b0000;
    #1;
    check("rst pending two", 32'(pend4), 32'b0110);
    check("rst m_a_source ch2", 32'(bus4.m_a_source), 32'd2);
    @(negedge clk);
    rstn4 = 1'b0;
    @(negedge clk);
    rstn4 = 1'b1;
    #1;
    check("rst pending cleared", 32'(pend4), 32'd0);
    check("rst m_a_valid", 32'(bus4.m_a_valid), 32'd0);
    check("rst stray cleared", 32'(stray4), 32'd0);
    bus4.ca_valid = 4'b1100;
    #1;
    check("rst first grant", 32'(bus4.ca_ready), 32'b0100);
    @(negedge clk);
    bus4.ca_valid = 4'b0000; bus4.m_d_valid = 1'b1; bus4.m_d_source = 4'd1;
    #1;
    check("rst stale cd_valid", 32'(bus4.cd_valid), 32'd0);
    check("rst stale m_d_ready", 32'(bus4.m_d_ready), 32'd1);
    check("rst pending ch2", 32'(pend4), 32'b0100);
    @(negedge clk);
    bus4.m_d_valid = 1'b0;
    #1;
    check("rst stale stray", 32'(stray4), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
